// File: rtl/imm_encode_loader_if.sv
// Field-bundle input stream and encoded-word output stream of imm_encode_loader.
// The master side produces bundles and consumes words; the slave side is the loader.
interface imm_encode_loader_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_op;
  logic [4:0]            in_rd;
  logic [2:0]            in_funct3;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic [2:0]            in_immsrc;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm, in_immsrc,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm, in_immsrc,
    output in_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/imm_encode_loader.sv
// Instruction word assembler: range-checks and packs an immediate into RISC-V
// bit positions, buffers finished words in a FIFO and streams them with byte addresses.
module imm_encode_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  imm_encode_loader_if.slave    bus,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  output logic                  err_sticky,
  output logic [7:0]            err_count,
  input  logic                  err_clr
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  logic                  r_s1_valid;
  logic                  r_s1_ok;
  logic [31:0]           r_s1_word;
  logic [31:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err_sticky;
  logic [7:0]            r_err_count;

  logic                  w_fire;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [31:0]           w_word;
  logic                  w_ok;
  logic                  w_sx11;
  logic                  w_sx12;
  logic                  w_sx20;
  logic [31:0]           w_i;

  assign w_fire      = bus.in_valid & r_in_ready;
  assign w_push      = r_s1_valid & r_s1_ok;
  assign w_drop      = r_s1_valid & ~r_s1_ok;
  assign w_pop       = r_out_valid & bus.out_ready;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Sign-extension checks: upper immediate bits must all equal the format's sign bit.
  assign w_i    = bus.in_imm;
  assign w_sx11 = (&w_i[31:11]) | ~(|w_i[31:11]);
  assign w_sx12 = (&w_i[31:12]) | ~(|w_i[31:12]);
  assign w_sx20 = (&w_i[31:20]) | ~(|w_i[31:20]);

  // Field packing and range check for the bundle currently on the input.
  always_comb begin
    w_word = '0;
    w_ok   = 1'b0;
    case (bus.in_immsrc)
      3'd0: begin
        w_word = {w_i[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_op};
        w_ok   = w_sx11;
      end
      3'd1: begin
        w_word = {w_i[12], w_i[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                  w_i[4:1], w_i[11], bus.in_op};
        w_ok   = ~w_i[0] & w_sx12;
      end
      3'd2: begin
        w_word = {w_i[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_i[4:0], bus.in_op};
        w_ok   = w_sx11;
      end
      3'd3: begin
        w_word = {w_i[20], w_i[10:1], w_i[11], w_i[19:12], bus.in_rd, bus.in_op};
        w_ok   = ~w_i[0] & w_sx20;
      end
      3'd4: begin
        w_word = {w_i[31:12], bus.in_rd, bus.in_op};
        w_ok   = ~(|w_i[11:0]);
      end
      3'd5: begin
        w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_op};
        w_ok   = 1'b1;
      end
      default: begin
        w_word = '0;
        w_ok   = 1'b0;
      end
    endcase
  end

  // S1 stage: one encoded word in flight, drained into the FIFO on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ok    <= 1'b0;
      r_s1_word  <= '0;
    end else begin
      r_s1_valid <= w_fire;
      if (w_fire) begin
        r_s1_ok   <= w_ok;
        r_s1_word <= w_word;
      end
    end
  end

  // Output FIFO; in_ready reserves a slot for the word sitting in S1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_s1_word;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_in_ready  <= (w_count_nxt + CNT_W'(w_fire)) < CNT_W'(FIFO_DEPTH);
    end
  end

  // Byte address of the head word; a load overrides the post-pop increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (addr_load) begin
      r_addr <= addr_base & ~ADDR_WIDTH'(3);
    end else if (w_pop) begin
      r_addr <= r_addr + ADDR_WIDTH'(4);
    end
  end

  // Dropped-bundle tracking; clear dominates a coincident drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (w_drop) begin
      r_err_sticky <= 1'b1;
      if (r_err_count != ERR_MAX) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_mem[r_rptr];
  assign bus.out_addr  = r_addr;
  assign err_sticky    = r_err_sticky;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Self-checking bench for imm_encode_loader: random bundles against a behavioural
// encoder model, plus directed latency, error, backpressure, address and reset scenarios.
module tb_imm_encode_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_load;
  logic [11:0] addr_base;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic        err_clr;

  imm_encode_loader_if #(.ADDR_WIDTH(12)) bus ();

  imm_encode_loader #(.ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .err_sticky(err_sticky),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          n_drop;
  int          cyc   = 0;
  bit          rand_rdy = 1'b0;
  logic [11:0] mdl_addr;
  logic [31:0] exp_q[$];
  logic [43:0] got_q[$];

  always @(posedge clk) cyc++;

  // Record every output handshake ({instr, addr}); the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      got_q.push_back({bus.out_instr, bus.out_addr});
  end

  // Reference encoder: range rules as signed intervals, fields placed by shift/mask.
  function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] f7,
                                          input logic [31:0] imm, input logic [2:0] src);
    int          s;
    bit          ok;
    logic [31:0] w;
    s  = $signed(imm);
    ok = 1'b0;
    w  = 32'd0;
    case (src)
      3'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      end
      3'd1: begin
        ok = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
        w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
           | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
           | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
      end
      3'd3: begin
        ok = (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
        w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
           | (32'(rd) << 7) | 32'(op);
      end
      3'd4: begin
        ok = (imm % 32'd4096) == 32'd0;
        w  = ((imm >> 12) << 12) | (32'(rd) << 7) | 32'(op);
      end
      3'd5: begin
        ok = 1'b1;
        w  = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
           | (32'(rd) << 7) | 32'(op);
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  // Offer one bundle until accepted (bounded); the model queue is updated on acceptance.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [2:0] src);
    int          tries;
    bit          acc;
    logic [32:0] r;
    bus.in_op = op; bus.in_rd = rd; bus.in_funct3 = f3; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_funct7 = f7; bus.in_imm = imm; bus.in_immsrc = src;
    bus.in_valid = 1'b1;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 200) begin
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", tries);
    end else begin
      r = ref_enc(op, rd, f3, rs1, rs2, f7, imm, src);
      if (r[32]) exp_q.push_back(r[31:0]);
      else n_drop++;
    end
  endtask

  task automatic gen_send(input bit allow_bad);
    logic [2:0]  src;
    logic [31:0] imm;
    src = allow_bad ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
    case (src)
      3'd0, 3'd2: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd1:       imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      3'd3:       imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
      3'd4:       imm = $urandom & 32'hFFFFF000;
      default:    imm = $urandom;
    endcase
    if (allow_bad && $urandom_range(0, 4) == 0) imm = $urandom;
    send(7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
         7'($urandom), imm, src);
  endtask

  // Bounded wait until the monitor has seen at least n words.
  task automatic wait_got(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (got_q.size() < n) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; addr_load = 1'b0; addr_base = '0; err_clr = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete(); got_q.delete();
    mdl_addr = '0; n_drop = 0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 ||
        bus.out_addr !== 12'd0 || err_sticky !== 1'b0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b instr=%h addr=%h st=%b cnt=%0d, required all 0",
               bus.in_ready, bus.out_valid, bus.out_instr, bus.out_addr, err_sticky, err_count);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release: in_ready=%b before first edge, required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: in_ready=%b after first edge, required 1", bus.in_ready);
    end
    exp_q.delete(); got_q.delete(); mdl_addr = '0; n_drop = 0;
  endtask

  task automatic test_addi();
    do_reset();
    bus.out_ready = 1'b1;
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF, 3'd0);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL addi_latency: out_valid=%b one edge after accept, required 0", bus.out_valid);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF00093 || bus.out_addr !== 12'h000) begin
      bad++;
      $display("FAIL addi_word: vld=%b instr=%h addr=%h, required 1 fff00093 000",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int          c0;
    logic [43:0] exp_w [3];
    exp_w[0] = {32'h00000463, 12'h000};
    exp_w[1] = {32'h001000EF, 12'h004};
    exp_w[2] = {32'h123452B7, 12'h008};
    do_reset();
    bus.out_ready = 1'b1;
    c0 = cyc;
    send(7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8, 3'd1);
    send(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800, 3'd3);
    send(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 3'd4);
    total++;
    if (cyc - c0 != 3) begin
      bad++; $display("FAIL b2b_throughput: %0d cycles for 3 bundles, required 3", cyc - c0);
    end
    wait_got(3);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL b2b_word%0d: missing, required %h", k, exp_w[k]);
      end else if (got_q[0] !== exp_w[k]) begin
        bad++; $display("FAIL b2b_word%0d: got %h, required %h", k, got_q[0], exp_w[k]);
        void'(got_q.pop_front());
      end else void'(got_q.pop_front());
    end
  endtask

  task automatic test_errors();
    do_reset();
    bus.out_ready = 1'b1;
    send(7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'h800, 3'd0);
    send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 3'd1);
    send(7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'd0, 3'd6);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 0 || err_sticky !== 1'b1 || err_count !== 8'd3 || bus.out_addr !== 12'd0) begin
      bad++;
      $display("FAIL err_drop: words=%0d st=%b cnt=%0d addr=%h, required 0 1 3 000",
               got_q.size(), err_sticky, err_count, bus.out_addr);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    total++;
    if (err_sticky !== 1'b0 || err_count !== 8'd0) begin
      bad++; $display("FAIL err_clear: st=%b cnt=%0d, required 0 0", err_sticky, err_count);
    end
    // Clear asserted on the very edge the dropped word leaves S1.
    send(7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'h1000, 3'd2);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    total++;
    if (err_sticky !== 1'b0 || err_count !== 8'd0) begin
      bad++; $display("FAIL err_clr_priority: st=%b cnt=%0d, required 0 0", err_sticky, err_count);
    end
    for (int k = 0; k < 258; k++)
      send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'(2 * k + 1), 3'd1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (err_count !== 8'd255 || err_sticky !== 1'b1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL err_saturate: cnt=%0d st=%b words=%0d, required 255 1 0",
               err_count, err_sticky, got_q.size());
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] imms [10] = '{32'h7FF, 32'hFFFFF800, 32'h800, 32'hFFFFF7FF, 32'hFFE,
                               32'hFFFFF000, 32'h1000, 32'hFFFFE, 32'hFFF00000, 32'h100000};
    logic [2:0]  srcs [10] = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3};
    logic [43:0] g;
    logic [31:0] e;
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++)
      send(7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
           7'($urandom), imms[k], srcs[k]);
    wait_got(exp_q.size());
    total++;
    if (err_count !== 8'(n_drop) || got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bound_counts: cnt=%0d words=%0d, required %0d %0d",
               err_count, got_q.size(), n_drop, exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== {e, mdl_addr}) begin
        bad++; $display("FAIL bound_word: got %h, required %h", g, {e, mdl_addr});
      end
      mdl_addr = mdl_addr + 12'd4;
    end
  endtask

  task automatic test_backpressure();
    logic [43:0] g;
    logic [31:0] e;
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) gen_send(1'b0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0 1", bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_before_pop: in_ready=%b, required 0", bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_after_pop: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    gen_send(1'b0);
    gen_send(1'b0);
    wait_got(6);
    total++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      bad++; $display("FAIL bp_count: words=%0d model=%0d, required 6", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== {e, mdl_addr}) begin
        bad++; $display("FAIL bp_word: got %h, required %h", g, {e, mdl_addr});
      end
      mdl_addr = mdl_addr + 12'd4;
    end
  endtask

  task automatic test_addr();
    logic [43:0] g;
    logic [31:0] e;
    do_reset();
    bus.out_ready = 1'b0;
    addr_load = 1'b1; addr_base = 12'hFFE;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    total++;
    if (bus.out_addr !== 12'hFFC) begin
      bad++; $display("FAIL addr_load: out_addr=%h, required ffc", bus.out_addr);
    end
    mdl_addr = 12'hFFC;
    gen_send(1'b0);
    gen_send(1'b0);
    bus.out_ready = 1'b1;
    wait_got(2);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== {e, mdl_addr}) begin
        bad++; $display("FAIL addr_wrap: got %h, required %h", g, {e, mdl_addr});
      end
      mdl_addr = mdl_addr + 12'd4;
    end
    bus.out_ready = 1'b0;
    gen_send(1'b0);
    gen_send(1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1; addr_load = 1'b1; addr_base = 12'h123;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    wait_got(2);
    total++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      bad++; $display("FAIL addr_coinc_count: words=%0d, required 2", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== {exp_q[0], mdl_addr} || got_q[1] !== {exp_q[1], 12'h120}) begin
        bad++;
        $display("FAIL addr_coinc: got %h %h, required %h %h", got_q[0], got_q[1],
                 {exp_q[0], mdl_addr}, {exp_q[1], 12'h120});
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic [43:0] g;
    logic [31:0] e;
    do_reset();
    rand_rdy = 1'b1;
    for (int k = 0; k < 80; k++) begin
      gen_send(1'b1);
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    wait_got(exp_q.size());
    total++;
    if (got_q.size() != exp_q.size() || err_count !== 8'(n_drop)) begin
      bad++;
      $display("FAIL rand_counts: words=%0d drops=%0d, required %0d %0d",
               got_q.size(), err_count, exp_q.size(), n_drop);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== {e, mdl_addr}) begin
        bad++; $display("FAIL rand_word: got %h, required %h", g, {e, mdl_addr});
      end
      mdl_addr = mdl_addr + 12'd4;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) gen_send(1'b0);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_queued: out_valid=%b, required 1", bus.out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b, required 0 0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete(); got_q.delete(); mdl_addr = '0;
    bus.out_ready = 1'b1;
    gen_send(1'b0);
    wait_got(1);
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      bad++; $display("FAIL mid_after_count: words=%0d, required 1", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== {exp_q[0], 12'h000}) begin
        bad++; $display("FAIL mid_after_word: got %h, required %h", got_q[0], {exp_q[0], 12'h000});
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = '0; bus.in_rd = '0; bus.in_funct3 = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.in_immsrc = '0;
    addr_load = 1'b0; addr_base = '0; err_clr = 1'b0;
    mdl_addr = '0; n_drop = 0;
    #2 rst = 1'b0;
    #20 rst = 1'b1;
    test_reset();
    test_addi();
    test_back_to_back();
    test_errors();
    test_boundaries();
    test_backpressure();
    test_addr();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encode_loader.md
# imm_encode_loader

Instruction word assembler and loader: the encoding counterpart of the control-path immediate extender. It accepts decoded instruction fields plus a full 32-bit immediate and an `ImmSrc` format code over a valid/ready stream, then range-checks and packs the immediate into RISC-V bit positions. Finished 32-bit words are buffered in a small FIFO and streamed out with an auto-incrementing byte address for writing into instruction memory. It is used by the program loader and test harness to build instruction memory images in hardware.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: byte address width of `out_addr`.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: block can accept a bundle.
- `in_op` input 7: opcode, bits [6:0].
- `in_rd` input 5: destination register.
- `in_funct3` input 3: funct3.
- `in_rs1` input 5: source register 1.
- `in_rs2` input 5: source register 2.
- `in_funct7` input 7: funct7, R-type only.
- `in_imm` input 32: full signed/unsigned immediate value.
- `in_immsrc` input 3: format code. 0=I, 1=B, 2=S, 3=J, 4=U, 5=R (no immediate), 6/7 illegal.
- `out_valid` output 1: FIFO head word valid.
- `out_ready` input 1: consumer accepts the head word.
- `out_instr` output 32: encoded instruction.
- `out_addr` output ADDR_WIDTH: byte address for `out_instr`.
- `addr_load` input 1: load the address counter.
- `addr_base` input ADDR_WIDTH: load value; bits [1:0] are forced to 0.
- `err_sticky` output 1: set on any dropped bundle.
- `err_count` output 8: dropped bundles, saturates at 255.
- `err_clr` input 1: clear `err_sticky` and `err_count`.

## Operation
- Stage S1 is a register holding the encoded word, its ok flag, and `s1_valid`. It captures on the input handshake (`in_valid && in_ready`).
- Encodings (op = `in_op`, f3 = `in_funct3`, i = `in_imm`):
  - I: {i[11:0], rs1, f3, rd, op}.
  - S: {i[11:5], rs2, rs1, f3, i[4:0], op}.
  - B: {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], op}.
  - J: {i[20], i[10:1], i[11], i[19:12], rd, op}.
  - U: {i[31:12], rd, op}.
  - R: {funct7, rs2, rs1, f3, rd, op}.
- Range checks (fail means not ok):
  - I/S: i[31:11] all equal.
  - B: i[0]==0 and i[31:12] all equal.
  - J: i[0]==0 and i[31:20] all equal.
  - U: i[11:0]==0.
  - R: always ok.
  - Codes 6/7: always fail.
- S1 → FIFO: on the edge after capture, an ok word is pushed. A failed word is dropped: `err_sticky` is set and `err_count` increments (saturating).
- `in_ready` = (FIFO occupancy + `s1_valid`) < `FIFO_DEPTH`. It depends on registered state only and never combinationally on `out_ready`.
- FIFO: `out_valid` = not empty. `out_instr` = head word. Simultaneous push and pop is legal when full or empty. Pointers wrap modulo `FIFO_DEPTH`.
- Address counter:
  - On an output handshake it increments by 4, wrapping modulo 2^ADDR_WIDTH.
  - `addr_load` loads {addr_base[ADDR_WIDTH-1:2], 2'b00}.
  - If load and pop occur in the same cycle, the popped word uses the old address and the load wins.
- `err_clr` takes priority over a simultaneous error event; the count is 0 afterwards.

## Timing
- Reset (async assert, while `rst`==0): `in_ready`=0, `out_valid`=0, `out_instr`=0, `out_addr`=0, `err_sticky`=0, `err_count`=0, FIFO empty, `s1_valid`=0.
  - `in_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-operation discards S1 and all FIFO contents. No partial output follows.
- Latency: a bundle accepted at edge N gives `out_valid`=1 after edge N+1, provided the FIFO was not blocked.
- Throughput: one bundle per cycle while `out_ready`=1.
- Backpressure: with `out_ready` held at 0, exactly `FIFO_DEPTH` bundles are accepted, then `in_ready`=0.
  - `in_ready` reasserts the cycle after the first pop.
- Words leave in acceptance order. Dropped words consume no address.

## Test plan
- I-type addi: op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF, immsrc=0 → `out_instr`=0xFFF00093, `out_addr`=0x000, two cycles after accept.
- B then J then U back-to-back with `out_ready`=1:
  - beq x0,x0 with imm=8 → 0x00000463 @0x000.
  - jal rd=1, imm=0x800 → 0x001000EF @0x004.
  - lui rd=5, imm=0x12345000 → 0x123452B7 @0x008.
- Errors: I imm=0x800, then B imm=3, then immsrc=6 → no output words, `err_sticky`=1, `err_count`=3, address unchanged. `err_clr` → both 0.
- Backpressure (DEPTH=4): `out_ready`=0, offer 6 bundles → 4 accepted, `in_ready`=0. Then `out_ready`=1 → all 6 emerge in order at 0x000–0x014.
- Address control:
  - `addr_load` with base=0xFFE → next word @0xFFC. Following word @0x000 (wrap).
  - Load coincident with a pop → popped word keeps the old address.
- Reset mid-stream with 3 words queued → `out_valid`=0 immediately. After release, the first new word is at 0x000.
